vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
- Downstream consumer of the 2-port VGA frame-buffer RAM.
- Generates 640x480@60 Hz raster timing on the 25 MHz pixel clock.
- Fetches 32-bit words from the buffer read port, one word per 32 pixels.
- Serializes each word into 1-bpp pixels and drives the board VGA pins: 4-bit R/G/B, hsync, vsync.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- FG_RGB, 12'hFFF, colour for pixel bit = 1 ({R,G,B} 4 bits each)
- BG_RGB, 12'h000, colour for pixel bit = 0
- ADDR_W, 14, frame-buffer word-address width (9600 words)

Ports:
- clock  in  1  25 MHz pixel clock
- reset  in  1  synchronous, active-high
- rdaddress  out  ADDR_W  frame-buffer word read address
- q  in  32  read data; registered inside the RAM, valid one clock after rdaddress
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- de  out  1  display enable, aligned with RGB
- frame_start  out  1  one-cycle pulse when h=0,v=0 reaches the output stage

Behaviour:
- Horizontal counter h_cnt: 0..799; wraps to 0 after 799.
- Vertical counter v_cnt: 0..524; increments when h_cnt wraps; wraps to 0 after 524.
- Reset: h_cnt=v_cnt=0.
- Stage 0 (counters) decode:
  - vis0 = (h_cnt<640)&&(v_cnt<480).
  - hs0 low for h_cnt 656..751.
  - vs0 low for v_cnt 490..491.
- rdaddress is combinational from stage 0:
  - When vis0: rdaddress = v_cnt*20 + h_cnt[9:5]. Computed as (v<<4)+(v<<2)+h[9:5]; max 9599.
  - Otherwise rdaddress = 0.
  - Value is meaningful only when h_cnt[4:0]==0; it is harmless at other cycles.
- Stage 1, one clock later: q holds the word requested at the previous h_cnt[4:0]==0.
  - Pixel bit:
    - If h1[4:0]==0 (delayed counter): pix = q[0], and shreg <= q>>1.
    - Else: pix = shreg[0], and shreg <= shreg>>1.
  - Bit order: pixel x within a word = bit x%32, LSB first. Byte 0 (data[7:0]) is the leftmost 8 pixels.
- Stage 2 (output registers):
  - {vga_r,vga_g,vga_b} = vis1 ? (pix ? FG_RGB : BG_RGB) : 12'h000.
  - de = vis1; vga_hs = hs1; vga_vs = vs1.
  - frame_start = (h1==0 && v1==0).
- Latency: counter value to pins = 2 clocks. Sync, de and RGB are mutually aligned.
- Reset values of all outputs:
  - vga_hs=1, vga_vs=1.
  - de=0, RGB=0, frame_start=0.
  - rdaddress=0.
  - Pipeline valid/sync shadows reset to inactive, so no spurious sync or colour is emitted during the first 2 clocks after reset.
- Reset mid-frame: takes effect on the next edge. Counters return to 0, all outputs inactive, shreg cleared. The raster restarts at (0,0); frame_start fires 2 clocks after reset deasserts.
- Blanking: RGB forced to 0 regardless of q and shreg. shreg contents outside the visible area are don't-care.
- No backpressure. The RAM read port is single-cycle, so reads are never stalled. Writes through the other port to the word currently being displayed take effect on the next fetch of that word (tearing is acceptable).

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants: H_TOTAL=800, V_TOTAL=525, sync start/end.
  - WORDS_PER_LINE=20, FB_WORDS=9600.
  - typedef t_rgb (struct of 3x4-bit).
- Sub-module vga_timing_gen contains the counters, visible/sync decode and frame_start source.
- The parent vga_fb_scanout holds address generation, shift register and output stage.

Test Plan:
- Reset held 5 clocks then released:
  - During reset: hs=vs=1, de=0, RGB=0.
  - frame_start pulses exactly 2 clocks after release.
- Free-run one line:
  - vga_hs low for exactly 96 clocks, starting 658 clocks after the line's h_cnt=0.
  - de high for 640 consecutive clocks per line.
- Address sequence: line 3 issues rdaddress 60,61,...,79 at h_cnt=0,32,...,608.
  - Last line issues 9580..9599.
  - No nonzero address during blanking.
- RAM model returns q=32'h0000_0001 for address 0, 0 elsewhere:
  - Only the first pixel of frame is FG_RGB (12'hFFF).
  - Pixels 1..639 of line 0 are 12'h000.
  - q=32'h8000_0000 at address 19 → only pixel 639 is lit.
- Full frame: vga_vs low for exactly 2 lines (1600 clocks), starting at line 490.
  - frame_start period is 420000 clocks.
- Assert reset at line 200, pixel 300 for one clock:
  - Outputs go inactive the next clock.
  - Raster restarts from (0,0); the next frame_start comes 2 clocks after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster constants and types for the VGA frame-buffer scan-out.
// The defaults describe 640x480@60 Hz with a 25 MHz pixel clock.
package vga_pkg;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    localparam int WORDS_PER_LINE = DEF_H_VIS / 32;
    localparam int FB_WORDS       = WORDS_PER_LINE * DEF_V_VIS;

    // 10 bits covers both the 800-pixel line and the 525-line frame.
    localparam int CNT_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } t_rgb;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational visible/sync/frame-origin decode.
// All outputs describe the current counter position (pipeline stage 0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic             clock,
    input  logic             reset,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             vis,
    output logic             hs,
    output logic             vs,
    output logic             first
);

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    assign h_cnt = h_cnt_reg;
    assign v_cnt = v_cnt_reg;
    assign vis   = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);
    // Sync pulses are active low over [START, END).
    assign hs    = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
    assign vs    = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
    assign first = (h_cnt_reg == '0) && (v_cnt_reg == '0);

endmodule

// File: rtl/vga_fb_scanout.sv
// Reads 1-bpp words from the frame buffer and drives the VGA pins.
// Counter-to-pin latency is two clocks: RAM read stage, then output registers.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int          H_VIS  = DEF_H_VIS,
    parameter int          H_FP   = DEF_H_FP,
    parameter int          H_SYNC = DEF_H_SYNC,
    parameter int          H_BP   = DEF_H_BP,
    parameter int          V_VIS  = DEF_V_VIS,
    parameter int          V_FP   = DEF_V_FP,
    parameter int          V_SYNC = DEF_V_SYNC,
    parameter int          V_BP   = DEF_V_BP,
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000,
    parameter int          ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [31:0]       q,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              de,
    output logic              frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             vis0;
    logic             hs0;
    logic             vs0;
    logic             first0;

    vga_timing_gen #(
        .H_VIS (H_VIS),
        .H_FP  (H_FP),
        .H_SYNC(H_SYNC),
        .H_BP  (H_BP),
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SYNC(V_SYNC),
        .V_BP  (V_BP)
    ) u_timing (
        .clock(clock),
        .reset(reset),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .vis  (vis0),
        .hs   (hs0),
        .vs   (vs0),
        .first(first0)
    );

    // Word address = v*20 + h/32, built from shifts so no multiplier is needed.
    logic [ADDR_W-1:0] v_ext;
    logic [ADDR_W-1:0] word_addr;

    assign v_ext     = ADDR_W'(v_cnt);
    assign word_addr = (v_ext << 4) + (v_ext << 2) + ADDR_W'(h_cnt[9:5]);
    assign rdaddress = vis0 ? word_addr : '0;

    // Stage 1: position delayed to line up with the RAM's registered q.
    logic [4:0] phase1_reg;
    logic       vis1_reg;
    logic       hs1_reg;
    logic       vs1_reg;
    logic       first1_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase1_reg <= '0;
            vis1_reg   <= 1'b0;
            hs1_reg    <= 1'b1;
            vs1_reg    <= 1'b1;
            first1_reg <= 1'b0;
        end else begin
            phase1_reg <= h_cnt[4:0];
            vis1_reg   <= vis0;
            hs1_reg    <= hs0;
            vs1_reg    <= vs0;
            first1_reg <= first0;
        end
    end

    // First pixel of a word comes straight from q; the rest from the shifter.
    logic [31:0] shreg_reg;
    logic        pix;

    assign pix = (phase1_reg == '0) ? q[0] : shreg_reg[0];

    // Stage 2: output registers.
    t_rgb rgb_reg;
    logic de_reg;
    logic hs_reg;
    logic vs_reg;
    logic fs_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_reg <= '0;
            rgb_reg   <= '0;
            de_reg    <= 1'b0;
            hs_reg    <= 1'b1;
            vs_reg    <= 1'b1;
            fs_reg    <= 1'b0;
        end else begin
            shreg_reg <= (phase1_reg == '0) ? {1'b0, q[31:1]} : {1'b0, shreg_reg[31:1]};
            rgb_reg   <= vis1_reg ? (pix ? FG_RGB : BG_RGB) : 12'h000;
            de_reg    <= vis1_reg;
            hs_reg    <= hs1_reg;
            vs_reg    <= vs1_reg;
            fs_reg    <= first1_reg;
        end
    end

    assign vga_r       = rgb_reg.r;
    assign vga_g       = rgb_reg.g;
    assign vga_b       = rgb_reg.b;
    assign de          = de_reg;
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: full 800-pixel lines, a shortened 13-line frame
// (6 visible, sync on lines 8..9) so a whole frame fits in a short run.
module tb_vga_fb_scanout;

    localparam int T_V_VIS  = 6;
    localparam int T_V_FP   = 2;
    localparam int T_V_SYNC = 2;
    localparam int T_V_BP   = 3;
    localparam int FRAME    = 800 * 13;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] rdaddress;
    logic [31:0] q;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        de;
    logic        frame_start;

    logic [31:0] mem [0:9599];

    always #20 clock = ~clock;

    // Frame-buffer read port with registered read data.
    always @(posedge clock) q <= mem[rdaddress];

    vga_fb_scanout #(
        .V_VIS (T_V_VIS),
        .V_FP  (T_V_FP),
        .V_SYNC(T_V_SYNC),
        .V_BP  (T_V_BP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rdaddress  (rdaddress),
        .q          (q),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .de         (de),
        .frame_start(frame_start)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    int k;
    int pos;
    int fs_count, fs_first_k, fs_last_k;
    int hs_low, hs_first_k;
    int de_cnt, de_first_k, de_last_k;
    int vs_low, vs_first_k;
    int bad_colour, blank_lit, blank_addr;
    int lit_pos[$];
    int line3_addr[$];
    int last_addr[$];
    int addr_err;

    initial begin
        for (int i = 0; i < 9600; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0000_0001;
        mem[19] = 32'h8000_0000;
        mem[40] = 32'h0000_00F0;

        reset = 1'b1;
        repeat (5) tick();
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_de", de, 0);
        check("rst_rgb", rgb(), 12'h000);
        check("rst_fs", frame_start, 0);
        check("rst_addr", rdaddress, 0);

        reset = 1'b0;
        fs_count = 0; fs_first_k = -1; fs_last_k = -1;
        hs_low = 0; hs_first_k = -1;
        de_cnt = 0; de_first_k = -1; de_last_k = -1;
        vs_low = 0; vs_first_k = -1;
        bad_colour = 0; blank_lit = 0; blank_addr = 0; addr_err = 0;

        for (k = 1; k <= FRAME + 2; k++) begin
            tick();
            pos = k - 2;
            if (k == 1) begin
                check("rel1_fs", frame_start, 0);
                check("rel1_de", de, 0);
                check("rel1_hs", vga_hs, 1);
            end
            if (frame_start) begin
                fs_count++;
                if (fs_first_k < 0) fs_first_k = k;
                fs_last_k = k;
            end
            if (k < 802) begin
                if (!vga_hs) begin
                    hs_low++;
                    if (hs_first_k < 0) hs_first_k = k;
                end
                if (de) begin
                    de_cnt++;
                    if (de_first_k < 0) de_first_k = k;
                    de_last_k = k;
                end
            end
            if (!vga_vs && k <= FRAME + 1) begin
                vs_low++;
                if (vs_first_k < 0) vs_first_k = k;
            end
            if (rgb() != 12'h000 && rgb() != 12'hFFF) bad_colour++;
            if (!de && rgb() != 12'h000) blank_lit++;
            if (pos >= 0 && pos < FRAME && rgb() != 12'h000) lit_pos.push_back(pos);
            // Counter position after k edges is (k % 800, k / 800).
            if ((k % 800) < 640 && (k / 800) < T_V_VIS) begin
                if ((k % 32) == 0 && (k / 800) == 3) line3_addr.push_back(int'(rdaddress));
                if ((k % 32) == 0 && (k / 800) == T_V_VIS - 1) last_addr.push_back(int'(rdaddress));
            end else if (rdaddress != 14'd0) begin
                blank_addr++;
            end
        end

        check("fs_first_k", fs_first_k, 2);
        check("fs_count", fs_count, 2);
        check("fs_period", fs_last_k - fs_first_k, FRAME);
        check("hs_start_k", hs_first_k, 658);
        check("hs_width", hs_low, 96);
        check("de_count", de_cnt, 640);
        check("de_first_k", de_first_k, 2);
        check("de_last_k", de_last_k, 641);
        check("vs_start_k", vs_first_k, 8 * 800 + 2);
        check("vs_width", vs_low, 1600);
        check("bad_colour", bad_colour, 0);
        check("blank_rgb", blank_lit, 0);
        check("blank_addr", blank_addr, 0);
        check("lit_count", lit_pos.size(), 6);
        if (lit_pos.size() == 6) begin
            check("lit0", lit_pos[0], 0);
            check("lit1", lit_pos[1], 639);
            check("lit2", lit_pos[2], 1604);
            check("lit5", lit_pos[5], 1607);
        end
        check("line3_n", line3_addr.size(), 20);
        check("last_n", last_addr.size(), 20);
        for (int i = 0; i < line3_addr.size() && i < 20; i++)
            if (line3_addr[i] != 60 + i) addr_err++;
        for (int i = 0; i < last_addr.size() && i < 20; i++)
            if (last_addr[i] != 100 + i) addr_err++;
        check("addr_seq_err", addr_err, 0);
        if (line3_addr.size() == 20) check("line3_last", line3_addr[19], 79);
        if (last_addr.size() == 20) check("last_last", last_addr[19], 119);

        // Run into frame 2 up to counters (300, 4), then pulse reset for one clock.
        while (k < FRAME + 4 * 800 + 300) begin
            tick();
            k++;
        end
        check("pre_rst_de", de, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_de", de, 0);
        check("mid_rst_rgb", rgb(), 12'h000);
        check("mid_rst_hs", vga_hs, 1);
        check("mid_rst_vs", vga_vs, 1);
        check("mid_rst_fs", frame_start, 0);
        reset = 1'b0;
        tick();
        check("mid_rel1_fs", frame_start, 0);
        check("mid_rel1_de", de, 0);
        tick();
        check("mid_rel2_fs", frame_start, 1);
        check("mid_rel2_rgb", rgb(), 12'hFFF);
        tick();
        check("mid_rel3_fs", frame_start, 0);
        check("mid_rel3_rgb", rgb(), 12'h000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
